// File: rtl/ppi_pkg.sv
// Shared constants and handshake state types for the clocked parallel peripheral interface.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: address of port 0, control-word bit offsets (counted down from the
// bus MSB so they track PORT_W), status-word bit indices and the two handshake
// state enums used by ppi_hs_ctrl.
package ppi_pkg;

    // Port 0 is the only port that can run the strobed handshake.
    localparam int ADDR_PORT0 = 0;

    // Control-word fields, as offsets below the bus MSB (bit index = PORT_W-1-offset).
    localparam int CTRL_MODE_OFS  = 0;   // 1 = mode word, 0 = bit set/reset
    localparam int CTRL_HS_EN_OFS = 1;   // handshake on port 0
    localparam int CTRL_INTE_OFS  = 2;   // handshake interrupt enable

    // Status word layout (read at the control address), zero-extended to PORT_W.
    localparam int ST_HS_EN = 0;
    localparam int ST_INTE  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_OBF_N = 3;
    localparam int ST_IBF   = 4;
    localparam int ST_INTR  = 5;
    localparam int ST_W     = 6;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_FULL = 1'b1
    } hs_in_t;

    typedef enum logic {
        OUT_IDLE     = 1'b0,
        OUT_WAIT_ACK = 1'b1
    } hs_out_t;

endpackage

// File: rtl/ppi_hs_ctrl.sv
// Port-0 strobed handshake: stb_n/ack_n synchronisers, input and output FSMs, ibf/obf_n/intr/ovr, input latch.
// Latency: pin edges act 3 clk after the pin changes (2-FF sync + edge register); bus events act on the next clk.
// Backpressure: none; a strobe arriving while the input buffer is full is dropped and flagged as overrun.
//
// Ports:
//   clk, Reset                 clock, synchronous active-high reset
//   i_hs_en, i_inte, i_dir0    control fields: handshake on, interrupt enable, port 0 direction (1 = input)
//   i_mode_wr                  a mode word commits this clk (clears all handshake state)
//   i_p0_wr                    a port-0 data write commits this clk
//   i_p0_rd_fall/i_p0_rd_rise  start / end of a CPU read of port 0
//   i_stb_n, i_ack_n           asynchronous pin strobes
//   i_pin0                     port 0 pins
//   o_in_latch, o_ibf, o_obf_n, o_intr, o_ovr   handshake state
module ppi_hs_ctrl
    import ppi_pkg::*;
#(
    parameter int PORT_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_hs_en,
    input  logic              i_inte,
    input  logic              i_dir0,
    input  logic              i_mode_wr,
    input  logic              i_p0_wr,
    input  logic              i_p0_rd_fall,
    input  logic              i_p0_rd_rise,
    input  logic              i_stb_n,
    input  logic              i_ack_n,
    input  logic [PORT_W-1:0] i_pin0,
    output logic [PORT_W-1:0] o_in_latch,
    output logic              o_ibf,
    output logic              o_obf_n,
    output logic              o_intr,
    output logic              o_ovr
);

    // [0],[1] are the synchroniser; [2] is the previous synchronised value for edge detection.
    logic [2:0]        r_stb_sync;
    logic [2:0]        r_ack_sync;
    hs_in_t            r_in_state;
    hs_out_t           r_out_state;
    logic [PORT_W-1:0] r_in_latch;
    logic              r_ibf;
    logic              r_obf_n;
    logic              r_intr;
    logic              r_ovr;

    logic w_stb_fall;
    logic w_stb_rise;
    logic w_ack_fall;
    logic w_ack_rise;
    logic w_mode_in;
    logic w_mode_out;

    assign w_stb_fall = r_stb_sync[2] & ~r_stb_sync[1];
    assign w_stb_rise = ~r_stb_sync[2] & r_stb_sync[1];
    assign w_ack_fall = r_ack_sync[2] & ~r_ack_sync[1];
    assign w_ack_rise = ~r_ack_sync[2] & r_ack_sync[1];

    assign w_mode_in  = i_hs_en & i_dir0;
    assign w_mode_out = i_hs_en & ~i_dir0;

    always_ff @(posedge clk) begin
        if (Reset) begin
            // Strobes idle high, so the synchronisers start high to avoid a false fall.
            r_stb_sync  <= 3'b111;
            r_ack_sync  <= 3'b111;
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
            r_in_latch  <= '0;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_stb_sync <= {r_stb_sync[1:0], i_stb_n};
            r_ack_sync <= {r_ack_sync[1:0], i_ack_n};

            if (i_mode_wr) begin
                r_in_state  <= IN_IDLE;
                r_out_state <= OUT_IDLE;
                r_ibf       <= 1'b0;
                r_obf_n     <= 1'b1;
                r_intr      <= 1'b0;
                r_ovr       <= 1'b0;
            end else if (w_mode_in) begin
                case (r_in_state)
                    IN_IDLE: begin
                        if (w_stb_fall) begin
                            r_in_latch <= i_pin0;
                            r_ibf      <= 1'b1;
                        end
                        // Only a strobe that actually loaded data completes the transfer.
                        if (w_stb_rise && r_ibf) begin
                            r_intr     <= i_inte;
                            r_in_state <= IN_FULL;
                        end
                    end
                    IN_FULL: begin
                        if (w_stb_fall) begin
                            r_ovr <= 1'b1;
                        end
                        if (i_p0_rd_fall) begin
                            r_intr <= 1'b0;
                        end
                        if (i_p0_rd_rise) begin
                            r_ibf      <= 1'b0;
                            r_in_state <= IN_IDLE;
                        end
                    end
                    default: r_in_state <= IN_IDLE;
                endcase
            end else if (w_mode_out) begin
                // A CPU write takes priority over any acknowledge edge in the same clk.
                if (i_p0_wr) begin
                    r_obf_n     <= 1'b0;
                    r_intr      <= 1'b0;
                    r_out_state <= OUT_WAIT_ACK;
                end else begin
                    if (w_ack_fall) begin
                        r_obf_n <= 1'b1;
                    end
                    if (w_ack_rise && (r_out_state == OUT_WAIT_ACK)) begin
                        r_intr      <= i_inte;
                        r_out_state <= OUT_IDLE;
                    end
                end
            end
        end
    end

    assign o_in_latch = r_in_latch;
    assign o_ibf      = r_ibf;
    assign o_obf_n    = r_obf_n;
    assign o_intr     = r_intr;
    assign o_ovr      = r_ovr;

endmodule

// File: rtl/ppi_sync_gen.sv
// Clocked parallel peripheral interface: NUM_PORTS ports with per-port direction, control/status, BSR, port-0 handshake.
// Latency: writes commit 1 clk after the write strobe first appears; reads are combinational from registered state.
// Backpressure: none; the CPU slave always accepts, a held write strobe commits only once.
//
// Ports:
//   clk, Reset                       clock, synchronous active-high reset
//   cs_n, rd_n, wr_n, addr           CPU bus controls (addr NUM_PORTS = control write / status read)
//   data_in, data_out, data_oe       CPU data and bus drive enable
//   port_in, port_out, port_oe       split pin interface, port p at [p*PORT_W +: PORT_W]
//   stb_n, ack_n                     asynchronous handshake strobes for port 0
//   ibf, obf_n, intr                 handshake flags
module ppi_sync_gen
    import ppi_pkg::*;
#(
    parameter int PORT_W    = 8,
    parameter int NUM_PORTS = 3,
    parameter int AW        = 2
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        cs_n,
    input  logic                        rd_n,
    input  logic                        wr_n,
    input  logic [AW-1:0]               addr,
    input  logic [PORT_W-1:0]           data_in,
    output logic [PORT_W-1:0]           data_out,
    output logic                        data_oe,
    input  logic [NUM_PORTS*PORT_W-1:0] port_in,
    output logic [NUM_PORTS*PORT_W-1:0] port_out,
    output logic [NUM_PORTS-1:0]        port_oe,
    input  logic                        stb_n,
    input  logic                        ack_n,
    output logic                        ibf,
    output logic                        obf_n,
    output logic                        intr
);

    localparam logic [AW-1:0] CTRL_ADDR = AW'(NUM_PORTS);
    localparam logic [AW-1:0] P0_ADDR   = AW'(ADDR_PORT0);
    localparam int            BSR_IW    = $clog2(PORT_W);

    // Bus decode
    logic              w_wr_act;
    logic              w_wr_commit;
    logic              w_rd_act;
    logic              w_rd_p0;
    logic              w_rd_p0_fall;
    logic              w_rd_p0_rise;
    logic              w_ctrl_sel;
    logic              w_mode_wr;
    logic              w_p0_wr;
    logic [BSR_IW-1:0] w_bsr_idx;

    logic r_wr_prev;
    logic r_rd_p0_prev;

    // Control register fields
    logic [NUM_PORTS-1:0] r_dir;     // 1 = input
    logic                 r_hs_en;
    logic                 r_inte;

    // Port latches and the registered pin stage
    logic [PORT_W-1:0]           r_port_out [NUM_PORTS];
    logic [NUM_PORTS*PORT_W-1:0] r_pin_q;

    // Handshake results
    logic [PORT_W-1:0] w_in_latch;
    logic              w_ibf;
    logic              w_obf_n;
    logic              w_intr;
    logic              w_ovr;

    logic [ST_W-1:0]   w_status;
    logic [PORT_W-1:0] w_rd_dat;

    assign w_wr_act    = ~cs_n & ~wr_n & rd_n;
    assign w_wr_commit = w_wr_act & ~r_wr_prev;
    assign w_rd_act    = ~cs_n & ~rd_n & wr_n;
    assign w_ctrl_sel  = (addr == CTRL_ADDR);
    assign w_mode_wr   = w_wr_commit & w_ctrl_sel & data_in[PORT_W-1-CTRL_MODE_OFS];
    assign w_p0_wr     = w_wr_commit & (addr == P0_ADDR);
    assign w_bsr_idx   = data_in[BSR_IW:1];

    // Read of port 0 is edge-detected so a multi-clk read counts once on each side.
    assign w_rd_p0      = w_rd_act & (addr == P0_ADDR);
    assign w_rd_p0_fall = w_rd_p0 & ~r_rd_p0_prev;
    assign w_rd_p0_rise = ~w_rd_p0 & r_rd_p0_prev;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_prev    <= 1'b0;
            r_rd_p0_prev <= 1'b0;
            r_dir        <= '1;
            r_hs_en      <= 1'b0;
            r_inte       <= 1'b0;
            r_pin_q      <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_port_out[p] <= '0;
            end
        end else begin
            r_wr_prev    <= w_wr_act;
            r_rd_p0_prev <= w_rd_p0;
            r_pin_q      <= port_in;

            if (w_wr_commit) begin
                if (w_ctrl_sel) begin
                    if (data_in[PORT_W-1-CTRL_MODE_OFS]) begin
                        r_dir   <= data_in[NUM_PORTS-1:0];
                        r_hs_en <= data_in[PORT_W-1-CTRL_HS_EN_OFS];
                        r_inte  <= data_in[PORT_W-1-CTRL_INTE_OFS];
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            r_port_out[p] <= '0;
                        end
                    end else begin
                        // Bit set/reset on the last port; indices past the port width are ignored.
                        for (int b = 0; b < PORT_W; b++) begin
                            if (w_bsr_idx == BSR_IW'(b)) begin
                                r_port_out[NUM_PORTS-1][b] <= data_in[0];
                            end
                        end
                    end
                end else begin
                    // Input ports still take the write; the value appears once the port turns around.
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (addr == AW'(p)) begin
                            r_port_out[p] <= data_in;
                        end
                    end
                end
            end
        end
    end

    ppi_hs_ctrl #(
        .PORT_W (PORT_W)
    ) u_hs_ctrl (
        .clk          (clk),
        .Reset        (Reset),
        .i_hs_en      (r_hs_en),
        .i_inte       (r_inte),
        .i_dir0       (r_dir[0]),
        .i_mode_wr    (w_mode_wr),
        .i_p0_wr      (w_p0_wr),
        .i_p0_rd_fall (w_rd_p0_fall),
        .i_p0_rd_rise (w_rd_p0_rise),
        .i_stb_n      (stb_n),
        .i_ack_n      (ack_n),
        .i_pin0       (port_in[PORT_W-1:0]),
        .o_in_latch   (w_in_latch),
        .o_ibf        (w_ibf),
        .o_obf_n      (w_obf_n),
        .o_intr       (w_intr),
        .o_ovr        (w_ovr)
    );

    always_comb begin
        w_status           = '0;
        w_status[ST_HS_EN] = r_hs_en;
        w_status[ST_INTE]  = r_inte;
        w_status[ST_OVR]   = w_ovr;
        w_status[ST_OBF_N] = w_obf_n;
        w_status[ST_IBF]   = w_ibf;
        w_status[ST_INTR]  = w_intr;
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        w_rd_dat = '0;
        if (w_ctrl_sel) begin
            w_rd_dat = PORT_W'(w_status);
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (addr == AW'(p)) begin
                    if (!r_dir[p]) begin
                        w_rd_dat = r_port_out[p];
                    end else if ((p == ADDR_PORT0) && r_hs_en) begin
                        w_rd_dat = w_in_latch;
                    end else begin
                        w_rd_dat = r_pin_q[p*PORT_W +: PORT_W];
                    end
                end
            end
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            assign port_out[gp*PORT_W +: PORT_W] = r_port_out[gp];
        end
    endgenerate

    assign port_oe  = ~r_dir;
    assign data_oe  = w_rd_act & ~Reset;
    assign data_out = w_rd_dat;
    assign ibf      = w_ibf;
    assign obf_n    = w_obf_n;
    assign intr     = w_intr;

endmodule

// File: tb/tb_ppi_sync_gen.sv
// Directed bench for ppi_sync_gen: stimulus queues expected values, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_ppi_sync_gen;

    localparam int PW = 8;
    localparam int NP = 3;
    localparam int AW = 2;

    localparam int K_RD   = 0;  // data_out on the first clk of a read
    localparam int K_POUT = 1;  // port_out of one port
    localparam int K_POE  = 2;  // port_oe
    localparam int K_PINS = 3;  // {ibf, obf_n, intr}

    logic             clk = 1'b0;
    logic             Reset;
    logic             cs_n, rd_n, wr_n;
    logic [AW-1:0]    addr;
    logic [PW-1:0]    data_in, data_out;
    logic             data_oe;
    logic [NP*PW-1:0] port_in, port_out;
    logic [NP-1:0]    port_oe;
    logic             stb_n, ack_n;
    logic             ibf, obf_n, intr;

    ppi_sync_gen #(.PORT_W(PW), .NUM_PORTS(NP), .AW(AW)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .port_in  (port_in),
        .port_out (port_out),
        .port_oe  (port_oe),
        .stb_n    (stb_n),
        .ack_n    (ack_n),
        .ibf      (ibf),
        .obf_n    (obf_n),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       kind;
        int       port;
        logic [7:0] exp;
        string    name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic probe_tgl  = 1'b0;
    logic probe_seen = 1'b0;
    logic oe_prev    = 1'b0;
    logic fire;
    exp_t e_cur;
    logic [7:0] got;

    // Monitor: a read is presented when data_oe rises; a pin snapshot when the probe toggles.
    always @(negedge clk) begin
        fire = (data_oe && !oe_prev) || (probe_tgl != probe_seen);
        oe_prev    = data_oe;
        probe_seen = probe_tgl;
        if (fire) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_output: DUT presented output with nothing expected");
            end else begin
                e_cur = sb_q.pop_front();
                case (e_cur.kind)
                    K_RD:    got = data_out;
                    K_POUT:  got = port_out[e_cur.port*PW +: PW];
                    K_POE:   got = {5'b0, port_oe};
                    default: got = {5'b0, ibf, obf_n, intr};
                endcase
                if (got !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h", e_cur.name, got, e_cur.exp);
                end
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [7:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; data_in = d;
        tick(1);
        cs_n = 1'b1; wr_n = 1'b1;
        tick(1);
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        push(K_RD, 0, exp, name);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        tick(1);
        cs_n = 1'b1; rd_n = 1'b1;
        tick(1);
    endtask

    task automatic probe(input int kind, input int port, input logic [7:0] exp, input string name);
        push(kind, port, exp, name);
        probe_tgl = ~probe_tgl;
        tick(1);
    endtask

    initial begin
        Reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; data_in = '0; stb_n = 1'b1; ack_n = 1'b1;
        port_in = {8'h33, 8'h22, 8'h11};
        tick(3);
        Reset = 1'b0;
        tick(2);

        // Reset state
        probe(K_POE,  0, 8'h00, "rst_port_oe");
        probe(K_PINS, 0, 8'h02, "rst_pins");
        probe(K_POUT, 1, 8'h00, "rst_port_out1");
        bus_rd(0, 8'h11, "rst_rd_p0");
        bus_rd(1, 8'h22, "rst_rd_p1");
        bus_rd(2, 8'h33, "rst_rd_p2");
        bus_rd(3, 8'h08, "rst_status");

        // Mode 0: port 0 input, ports 1 and 2 outputs
        bus_wr(3, 8'h81);
        bus_wr(1, 8'hA5);
        port_in[7:0] = 8'h6B;
        tick(2);
        probe(K_POE,  0, 8'h06, "m0_port_oe");
        probe(K_POUT, 1, 8'hA5, "m0_port_out1");
        bus_rd(0, 8'h6B, "m0_rd_pin0");
        bus_rd(1, 8'hA5, "m0_rd_p1");
        bus_rd(3, 8'h08, "m0_status");

        // BSR on the last port
        bus_wr(2, 8'hF0);
        bus_wr(3, 8'h07);
        probe(K_POUT, 2, 8'hF8, "bsr_set_bit3");
        bus_wr(3, 8'h06);
        probe(K_POUT, 2, 8'hF0, "bsr_clr_bit3");
        probe(K_POUT, 1, 8'hA5, "bsr_p1_untouched");
        probe(K_POE,  0, 8'h06, "bsr_ctrl_untouched");

        // Mode 1 input on port 0
        bus_wr(3, 8'hE1);
        port_in[7:0] = 8'h3C;
        tick(1);
        stb_n = 1'b0;
        tick(4);
        probe(K_PINS, 0, 8'h06, "in_ibf_set");
        stb_n = 1'b1;
        tick(2);
        probe(K_PINS, 0, 8'h06, "in_intr_2clk");
        probe(K_PINS, 0, 8'h07, "in_intr_3clk");
        port_in[7:0] = 8'h99;
        stb_n = 1'b0;
        tick(4);
        stb_n = 1'b1;
        tick(4);
        bus_rd(3, 8'h3F, "in_status_ovr");
        bus_rd(0, 8'h3C, "in_rd_latch");
        bus_rd(3, 8'h0F, "in_status_after_rd");
        probe(K_PINS, 0, 8'h02, "in_pins_after_rd");

        // Mode 1 output on port 0
        bus_wr(3, 8'hE0);
        bus_wr(0, 8'h55);
        probe(K_POUT, 0, 8'h55, "out_port_out0");
        probe(K_PINS, 0, 8'h00, "out_obf_low");
        ack_n = 1'b0;
        tick(3);
        probe(K_PINS, 0, 8'h02, "out_obf_ack");
        ack_n = 1'b1;
        tick(3);
        probe(K_PINS, 0, 8'h03, "out_intr");
        probe(K_POE,  0, 8'h07, "out_port_oe");

        // Write and synchronised ack fall act in the same clk: write wins
        ack_n = 1'b0;
        tick(2);
        bus_wr(0, 8'h5A);
        probe(K_PINS, 0, 8'h00, "same_clk_obf");
        ack_n = 1'b1;
        tick(4);
        probe(K_PINS, 0, 8'h01, "same_clk_after_ack");
        probe(K_POUT, 0, 8'h5A, "same_clk_port_out0");

        // Reset in the middle of an input handshake
        bus_wr(3, 8'hE1);
        bus_wr(2, 8'h5A);
        port_in[7:0] = 8'h42;
        stb_n = 1'b0;
        tick(4);
        probe(K_PINS, 0, 8'h06, "pre_rst_ibf");
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        probe(K_PINS, 0, 8'h02, "mid_rst_pins");
        probe(K_POE,  0, 8'h00, "mid_rst_port_oe");
        probe(K_POUT, 2, 8'h00, "mid_rst_port_out2");
        stb_n = 1'b1;
        tick(2);
        bus_rd(3, 8'h08, "mid_rst_status");
        bus_rd(0, 8'h42, "mid_rst_rd_pin0");

        // A long write strobe commits only its first value
        bus_wr(3, 8'h80);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'd1; data_in = 8'h11;
        tick(1);
        data_in = 8'h22;
        tick(3);
        cs_n = 1'b1; wr_n = 1'b1;
        tick(1);
        probe(K_POUT, 1, 8'h11, "long_wr_once");
        bus_rd(1, 8'h11, "long_wr_rd");

        // Bounded drain of anything still expected
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            tick(1);
        end
        while (sb_q.size() != 0) begin
            e_cur = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: no output seen, expected 0x%02h", e_cur.name, e_cur.exp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
